// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic lamp / pedestrian controller: light codes,
// pedestrian FSM states and 7-segment patterns (active-high, gfedcba).
package traffic_pkg;

  typedef enum logic [1:0] {
    RED     = 2'b00,
    YELLOW  = 2'b01,
    GREEN   = 2'b10,
    INVALID = 2'b11
  } light_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    WALK  = 2'b10,
    CLEAR = 2'b11
  } ped_state_t;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  function automatic logic [6:0] seg7_pattern(input logic [3:0] v);
    case (v)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return 7'b0000000;
    endcase
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Single decimal digit to 7-segment (gfedcba) decoder with a blanking input.
module seg7_dec
  import traffic_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? 7'b0000000 : seg7_pattern(value);
  end

endmodule

// File: rtl/traffic_lamp_ped_ctrl.sv
// Lamp driver, countdown display and pedestrian WALK sequencer, all slaved to
// a registered copy of the light controller's state and timer.
module traffic_lamp_ped_ctrl
  import traffic_pkg::*;
#(
  parameter int FLASH_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] light_state,
  input  logic [3:0] timer,
  input  logic       ped_btn,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic       walk,
  output logic       dont_walk,
  output logic       ped_wait,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic       fault
);

  light_t     st_q, st_d, st_prev_q, st_prev_d;
  logic [3:0] tm_q, tm_d;
  logic       btn_q, btn_d, btn_prev_q, btn_prev_d;
  ped_state_t ps_q, ps_d;
  logic       pend_q, pend_d;
  logic [7:0] cnt_q, cnt_d;
  logic       flash_q, flash_d;
  logic       walk_q, walk_d, dw_q, dw_d, pw_q, pw_d;

  logic       btn_edge, red_entry, restart;
  logic       tens_blank;
  logic [3:0] ones_val;

  assign fault     = (st_q == INVALID);
  assign btn_edge  = btn_q & ~btn_prev_q;
  assign red_entry = (st_q == RED) && (st_prev_q != RED);

  always_comb begin
    st_d       = light_t'(light_state);
    tm_d       = timer;
    btn_d      = ped_btn;
    st_prev_d  = st_q;
    btn_prev_d = btn_q;
    ps_d       = ps_q;
    pend_d     = pend_q;

    if (fault) begin
      ps_d   = IDLE;
      pend_d = 1'b0;
    end else begin
      case (ps_q)
        IDLE: if (btn_edge) ps_d = WAIT;
        // A red phase that starts with too little time left skips WALK.
        WAIT: if (red_entry) ps_d = (tm_q <= 4'd3) ? CLEAR : WALK;
        WALK: begin
          if (btn_edge) pend_d = 1'b1;
          if (st_q == RED && tm_q <= 4'd3) ps_d = CLEAR;
        end
        CLEAR: begin
          if (btn_edge) pend_d = 1'b1;
          if (st_q != RED) begin
            ps_d   = (pend_q || btn_edge) ? WAIT : IDLE;
            pend_d = 1'b0;
          end
        end
        default: ps_d = IDLE;
      endcase
    end

    // Restart aligned with the edge that makes fault/CLEAR visible, so the
    // flashing lamp starts ON in its first cycle.
    restart = (st_d == INVALID && st_q != INVALID) || (ps_d == CLEAR && ps_q != CLEAR);
    if (restart) begin
      cnt_d   = 8'd0;
      flash_d = 1'b1;
    end else if (cnt_q == 8'(FLASH_DIV - 1)) begin
      cnt_d   = 8'd0;
      flash_d = ~flash_q;
    end else begin
      cnt_d   = cnt_q + 8'd1;
      flash_d = flash_q;
    end

    walk_d = (ps_d == WALK);
    dw_d   = (ps_d == WALK) ? 1'b0 : (ps_d == CLEAR) ? flash_d : 1'b1;
    pw_d   = (ps_d == WAIT) || pend_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= RED;
      st_prev_q  <= RED;
      tm_q       <= 4'd0;
      btn_q      <= 1'b1;
      btn_prev_q <= 1'b1;
      ps_q       <= IDLE;
      pend_q     <= 1'b0;
      cnt_q      <= 8'd0;
      flash_q    <= 1'b1;
      walk_q     <= 1'b0;
      dw_q       <= 1'b1;
      pw_q       <= 1'b0;
    end else begin
      st_q       <= st_d;
      st_prev_q  <= st_prev_d;
      tm_q       <= tm_d;
      btn_q      <= btn_d;
      btn_prev_q <= btn_prev_d;
      ps_q       <= ps_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      flash_q    <= flash_d;
      walk_q     <= walk_d;
      dw_q       <= dw_d;
      pw_q       <= pw_d;
    end
  end

  assign lamp_red    = (st_q == RED);
  assign lamp_green  = (st_q == GREEN);
  assign lamp_yellow = fault ? flash_q : (st_q == YELLOW);
  assign walk        = walk_q;
  assign dont_walk   = dw_q;
  assign ped_wait    = pw_q;

  assign tens_blank = fault || (tm_q < 4'd10);
  assign ones_val   = (tm_q >= 4'd10) ? (tm_q - 4'd10) : tm_q;

  seg7_dec u_tens (
    .value (4'd1),
    .blank (tens_blank),
    .seg   (seg_tens)
  );

  seg7_dec u_ones (
    .value (ones_val),
    .blank (fault),
    .seg   (seg_ones)
  );

endmodule

// File: tb/tb_traffic_lamp_ped_ctrl.sv
// Directed bench: stimulus queues expected values tagged with the cycle they
// are due; a negedge monitor pops and compares them.
module tb_traffic_lamp_ped_ctrl;

  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] light_state = 2'b10;
  logic [3:0] timer = 4'd5;
  logic       ped_btn = 1'b1;
  logic       lamp_red, lamp_yellow, lamp_green, walk, dont_walk, ped_wait, fault;
  logic [6:0] seg_tens, seg_ones;

  traffic_lamp_ped_ctrl #(.FLASH_DIV(FD)) dut (
    .clk         (clk),
    .rst         (rst),
    .light_state (light_state),
    .timer       (timer),
    .ped_btn     (ped_btn),
    .lamp_red    (lamp_red),
    .lamp_yellow (lamp_yellow),
    .lamp_green  (lamp_green),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .ped_wait    (ped_wait),
    .seg_tens    (seg_tens),
    .seg_ones    (seg_ones),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {C_RED, C_YEL, C_GRN, C_WALK, C_DW, C_PW, C_FAULT, C_TENS, C_ONES} sig_e;
  typedef struct {
    int         at;
    sig_e       sig;
    logic [6:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  localparam logic [1:0] L_RED = 2'b00, L_YEL = 2'b01, L_GRN = 2'b10, L_BAD = 2'b11;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Flash phase n cycles after a restart (starts ON).
  function automatic bit fl(input int n);
    return ((n / FD) % 2) == 0;
  endfunction

  function automatic logic [6:0] actual(input sig_e s);
    case (s)
      C_RED:   return {6'b0, lamp_red};
      C_YEL:   return {6'b0, lamp_yellow};
      C_GRN:   return {6'b0, lamp_green};
      C_WALK:  return {6'b0, walk};
      C_DW:    return {6'b0, dont_walk};
      C_PW:    return {6'b0, ped_wait};
      C_FAULT: return {6'b0, fault};
      C_TENS:  return seg_tens;
      default: return seg_ones;
    endcase
  endfunction

  task automatic expect_v(input int off, input sig_e s, input logic [6:0] v);
    exp_t e;
    e.at  = cyc + off;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_b(input int off, input sig_e s, input bit b);
    expect_v(off, s, {6'b0, b});
  endtask

  task automatic drive(input logic [1:0] ls, input logic [3:0] t, input logic b);
    light_state = ls;
    timer       = t;
    ped_btn     = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].at == cyc) begin
        checks++;
        if (actual(sb[i].sig) !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc %0d got %h want %h", sb[i].sig.name(), cyc,
                   actual(sb[i].sig), sb[i].val);
        end else begin
          $display("ok   %s cyc %0d = %h", sb[i].sig.name(), cyc, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].at < cyc || done) begin
        checks++;
        errors++;
        $display("FAIL %s never checked, due cyc %0d", sb[i].sig.name(), sb[i].at);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with button held and a non-red light on the inputs.
    tick();
    expect_b(1, C_RED, 1); expect_b(1, C_YEL, 0); expect_b(1, C_GRN, 0);
    expect_b(1, C_WALK, 0); expect_b(1, C_DW, 1); expect_b(1, C_PW, 0);
    expect_b(1, C_FAULT, 0); expect_v(1, C_TENS, 7'h00); expect_v(1, C_ONES, 7'h3F);
    tick();
    rst = 1'b0;
    drive(L_RED, 4'd0, 1'b1);
    expect_b(1, C_PW, 0); expect_b(2, C_PW, 0);
    tick();
    tick();
    drive(L_RED, 4'd0, 1'b0);
    tick();
    drive(L_RED, 4'd0, 1'b1);
    expect_b(1, C_PW, 0); expect_b(2, C_PW, 1); expect_b(2, C_DW, 1);
    tick();
    // Green tm 5, then red tm 10.
    drive(L_GRN, 4'd5, 1'b0);
    expect_b(1, C_GRN, 1); expect_b(1, C_RED, 0);
    expect_v(1, C_ONES, seg(5)); expect_v(1, C_TENS, 7'h00);
    tick();
    tick();
    drive(L_RED, 4'd10, 1'b0);
    expect_b(1, C_RED, 1); expect_v(1, C_TENS, seg(1)); expect_v(1, C_ONES, seg(0));
    expect_b(1, C_WALK, 0); expect_b(2, C_WALK, 1); expect_b(2, C_DW, 0); expect_b(2, C_PW, 0);
    tick();
    // Countdown through WALK into flashing CLEAR; press during WALK.
    for (int c = 9; c <= 26; c++) begin
      int tm;
      tm = (c <= 18) ? 18 - c : 0;
      drive(L_RED, 4'(tm), c == 11);
      expect_v(1, C_ONES, seg(tm));
      expect_b(2, C_WALK, (c + 2) < 17);
      expect_b(2, C_PW, (c + 2) >= 13);
      expect_b(2, C_DW, ((c + 2) < 17) ? 1'b0 : fl(c + 2 - 17));
      tick();
    end
    // Leave red with a pending request -> WAIT, then next red grants WALK.
    drive(L_YEL, 4'd2, 1'b0);
    expect_b(1, C_YEL, 1); expect_b(1, C_RED, 0);
    expect_b(2, C_PW, 1); expect_b(2, C_DW, 1); expect_b(2, C_WALK, 0);
    tick();
    drive(L_GRN, 4'd5, 1'b0);
    tick();
    tick();
    drive(L_RED, 4'd12, 1'b0);
    expect_b(1, C_WALK, 0); expect_v(1, C_TENS, seg(1)); expect_v(1, C_ONES, seg(2));
    expect_b(2, C_WALK, 1); expect_b(2, C_PW, 0);
    tick();
    drive(L_RED, 4'd11, 1'b0);
    tick();
    // Fault during WALK; a press during fault is ignored.
    for (int c = 32; c <= 40; c++) begin
      drive(L_BAD, 4'd11, c == 34);
      if (c == 32) expect_b(1, C_WALK, 1);
      expect_b(1, C_FAULT, 1); expect_b(1, C_YEL, fl(c + 1 - 33));
      expect_b(1, C_RED, 0); expect_b(1, C_GRN, 0);
      expect_v(1, C_TENS, 7'h00); expect_v(1, C_ONES, 7'h00);
      expect_b(2, C_WALK, 0); expect_b(2, C_DW, 1); expect_b(2, C_PW, 0);
      tick();
    end
    drive(L_GRN, 4'd5, 1'b0);
    expect_b(1, C_FAULT, 0); expect_b(1, C_YEL, 0); expect_b(1, C_GRN, 1);
    expect_v(1, C_ONES, seg(5)); expect_b(2, C_PW, 0);
    tick();
    drive(L_GRN, 4'd5, 1'b1);
    expect_b(2, C_PW, 1);
    tick();
    drive(L_GRN, 4'd5, 1'b0);
    tick();
    // Red entered with tm 2 from WAIT: straight to CLEAR, WALK never shown.
    for (int c = 44; c <= 51; c++) begin
      drive(L_RED, 4'd2, 1'b0);
      if (c == 44) expect_b(1, C_DW, 1);
      expect_b(2, C_WALK, 0);
      expect_b(2, C_DW, fl(c + 2 - 46));
      expect_b(2, C_PW, 0);
      tick();
    end
    drive(L_GRN, 4'd5, 1'b0);
    expect_b(2, C_PW, 0); expect_b(2, C_DW, 1);
    tick();
    tick();
    // Button edge and red entry together in IDLE: WAIT only.
    drive(L_RED, 4'd9, 1'b1);
    expect_b(2, C_PW, 1); expect_b(2, C_WALK, 0);
    tick();
    drive(L_RED, 4'd9, 1'b0);
    expect_b(2, C_WALK, 0);
    tick();
    drive(L_GRN, 4'd5, 1'b0);
    tick();
    drive(L_RED, 4'd9, 1'b0);
    expect_b(1, C_WALK, 0);
    tick();
    drive(L_RED, 4'd8, 1'b0);
    expect_b(1, C_WALK, 1);
    tick();
    // Reset mid-WALK.
    rst = 1'b1;
    expect_b(1, C_WALK, 0); expect_b(1, C_RED, 1); expect_v(1, C_ONES, 7'h3F);
    expect_v(1, C_TENS, 7'h00); expect_b(1, C_DW, 1); expect_b(1, C_PW, 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_ped_ctrl.md
TRAFFIC_LAMP_PED_CTRL -- requirements
Module: traffic_lamp_ped_ctrl

Interface
REQ-001 The module SHALL have these ports (clock and reset first):
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- light_state  in  2  light-controller state code: 00 red, 01 yellow, 10 green, 11 invalid
- timer  in  4  light-controller countdown, 0-15
- ped_btn  in  1  pedestrian push button, level, already synchronised
- lamp_red, lamp_yellow, lamp_green  out  1 each  lamp drives
- walk  out  1  pedestrian WALK lamp
- dont_walk  out  1  pedestrian DON'T WALK lamp (steady or flashing)
- ped_wait  out  1  "request accepted" indicator
- seg_tens, seg_ones  out  7 each  countdown digits, active-high, bit order gfedcba
- fault  out  1  invalid light_state present
REQ-002 Parameter FLASH_DIV, default 8, SHALL set the cycles per flash half-period, legal range 2-255.

Function
REQ-003 light_state and timer SHALL be registered once on clk (st_q, tm_q). All outputs SHALL derive from st_q/tm_q, so input-to-output latency is 1 cycle (lamps, digits) or 2 cycles (walk FSM outputs).
REQ-004 Lamps SHALL be one-hot from st_q: 00 -> red, 01 -> yellow, 10 -> green.
REQ-005 st_q = 11 SHALL assert fault and turn red and green off. It SHALL flash yellow from the shared flash toggle, starting ON in the first fault cycle.
REQ-006 A free-running flash prescaler SHALL count 0..FLASH_DIV-1, wrap to 0, and toggle flash_ph on each wrap. It SHALL restart at 0, with flash_ph = 1, on any fault or CLEAR entry.
REQ-007 The digits SHALL show tm_q in decimal. seg_tens SHALL be blank (0) when tm_q < 10. For 10-15, seg_tens SHALL show "1" and seg_ones SHALL show tm_q-10.
REQ-008 Both digits SHALL be blanked while fault = 1.
REQ-009 A rising edge on ped_btn SHALL be detected as ped_btn high with its previous registered value low; a held button SHALL count once.
REQ-010 The pedestrian FSM SHALL have states IDLE, WAIT, WALK and CLEAR.
- IDLE -> WAIT on a button edge.
- WAIT -> WALK on the first cycle where st_q becomes red (previous st_q not red). Entering red while already red does not count.
- WALK -> CLEAR when st_q = red and tm_q <= 3.
- CLEAR -> IDLE when st_q leaves red. If a request is pending, the FSM SHALL go to WAIT instead.
REQ-011 Outputs per state:
- walk = 1 only in WALK.
- dont_walk = 1 in IDLE and WAIT, 0 in WALK, and equal to flash_ph in CLEAR.
- ped_wait = 1 in WAIT, or when the pending flag is set.
REQ-012 A button edge in WALK or CLEAR SHALL set the pending flag. The flag SHALL be cleared on CLEAR exit, when the FSM enters WAIT.
REQ-013 A WAIT -> WALK transition into a red phase entered with tm_q <= 3 SHALL go directly to CLEAR. WALK SHALL never be shown with fewer than 4 counts remaining.
REQ-014 If fault asserts in any state, the FSM SHALL go to IDLE next cycle. It SHALL also clear the pending flag and drive walk = 0 and dont_walk = 1 (steady). A button edge during fault SHALL be ignored.
REQ-015 A button edge and a red entry in the same cycle while in IDLE SHALL go to WAIT only; WALK is granted on the following red entry.

Reset
REQ-016 While rst = 1 at a clk edge, the module SHALL load: st_q = red, tm_q = 0, FSM IDLE, pending = 0, prescaler = 0, flash_ph = 1, button history = 1.
REQ-017 Outputs after reset SHALL be: lamp_red = 1, other lamps 0, walk = 0, dont_walk = 1, ped_wait = 0, fault = 0, seg_tens = 0, seg_ones = "0" (0111111).
REQ-018 Because the button history resets to 1, a button held through reset SHALL NOT register an edge.
REQ-019 rst asserted mid-WALK SHALL drop walk on the first clk edge with rst high.

Structure
REQ-020 Package traffic_pkg SHALL hold:
- the light-state encodings (RED, YELLOW, GREEN, INVALID)
- the pedestrian FSM state enum
- the 7-segment pattern constants for 0-9
REQ-021 One sub-module, seg7_dec, SHALL convert a 4-bit value 0-9 to 7-segment form plus a blank input. It SHALL be instantiated twice.
REQ-022 The module SHALL be fully synchronous on clk rising edge, with no latches.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset with ped_btn high -> lamp_red = 1, dont_walk = 1, ped_wait = 0; release and re-press -> ped_wait = 1 two cycles after the edge.
- Green tm = 5, press, then red with tm = 10 -> walk = 1 two cycles after red entry. Digits show "1","0".
- While red, timer counts down -> walk drops when tm_q = 3; dont_walk flashes with a period of 2*FLASH_DIV cycles.
- Press during WALK -> ped_wait stays 1; after yellow/green the next red entry grants WALK again.
- light_state = 11 during WALK -> fault = 1, walk = 0 next cycle, digits blank, yellow flashes.
- Red entered with tm = 2 while in WAIT -> FSM goes to CLEAR directly; walk never asserts.
